// File: rtl/dvi_pkg.sv
// Shared constants for the DVI scan-out controller: FSM encodings,
// default 640x480 geometry and the frame counter width.
package dvi_pkg;

    localparam int DVI_H_ACTIVE = 640;
    localparam int DVI_V_ACTIVE = 480;
    localparam int DVI_BURST    = 16;
    localparam int DVI_ADDR_W   = 24;
    localparam int FRAME_CNT_W  = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ARM        = 3'd1;
    localparam state_t ST_PREFETCH   = 3'd2;
    localparam state_t ST_WAIT_LINE  = 3'd3;
    localparam state_t ST_WAIT_VSYNC = 3'd4;
    localparam state_t ST_STOP       = 3'd5;

endpackage

// File: rtl/dvi_edge_detect.sv
// Purpose: one-register edge detector for a timing-generator strobe.
// Latency: rise/fall are combinational against the previous sampled level.
// Backpressure: none; samples every cycle.
module dvi_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            din_d <= 1'b0;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;
    assign fall = ~din & din_d;

endmodule

// File: rtl/dvi_scanout_ctrl.sv
// Purpose: starts the DVI timing generator and prefetches each active line as read bursts.
// Latency: tg_start two cycles after enable; sync edges act on the clock edge that first samples them.
// Backpressure: rd_req/rd_addr hold until rd_ack; stop and resync wait for the outstanding ack.
module dvi_scanout_ctrl
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE = DVI_H_ACTIVE,
    parameter int V_ACTIVE = DVI_V_ACTIVE,
    parameter int BURST    = DVI_BURST,
    parameter int ADDR_W   = DVI_ADDR_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [ADDR_W-1:0]      fb_base,
    output logic                   tg_start,
    input  logic                   vsync_in,
    input  logic                   ve_in,
    output logic                   rd_req,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_ack,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   underflow,
    output logic                   busy
);

    localparam int BURSTS = H_ACTIVE / BURST;
    localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int IDX_W  = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    localparam logic [LINE_W-1:0] LAST_LINE    = LINE_W'(V_ACTIVE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(BURSTS - 1);
    localparam logic [ADDR_W-1:0] LINE_STRIDE  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BURST);

    generate
        if ((BURSTS < 1) || (H_ACTIVE % BURST != 0)) begin : g_bad_geometry
            $error("dvi_scanout_ctrl: H_ACTIVE must be a non-zero multiple of BURST");
        end
    endgenerate

    state_t                   state;
    logic                     tg_q;
    logic                     req_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [ADDR_W-1:0]        frame_base;
    logic [LINE_W-1:0]        line_cnt;
    logic [IDX_W-1:0]         burst_idx;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;
    logic                     uf_q;
    logic                     stop_pend;
    logic                     resync_pend;

    logic vs_rise;
    logic vs_fall_unused;
    logic ve_rise;
    logic ve_fall;

    logic in_frame;
    logic stopping;
    logic req_held;
    logic frame_inc;
    logic restart;

    dvi_edge_detect u_vs_edge (
        .clock (clock),
        .reset (reset),
        .din   (vsync_in),
        .rise  (vs_rise),
        .fall  (vs_fall_unused)
    );

    dvi_edge_detect u_ve_edge (
        .clock (clock),
        .reset (reset),
        .din   (ve_in),
        .rise  (ve_rise),
        .fall  (ve_fall)
    );

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LINE_W-1:0] line);
        return base + ADDR_W'(line) * LINE_STRIDE;
    endfunction

    // Stop beats everything, including a coincident vsync; a request already on the bus
    // is never withdrawn, so stop and resync both park until its ack.
    always_comb begin
        in_frame  = (state == ST_PREFETCH) || (state == ST_WAIT_LINE) || (state == ST_WAIT_VSYNC);
        stopping  = (state != ST_IDLE) && (state != ST_STOP) && (!enable || stop_pend);
        req_held  = req_q & ~rd_ack;
        frame_inc = in_frame && !stopping && vs_rise;
        restart   = in_frame && !stopping && (vs_rise || resync_pend) && !req_held;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            tg_q        <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            frame_base  <= '0;
            line_cnt    <= '0;
            burst_idx   <= '0;
            frame_cnt_q <= '0;
            uf_q        <= 1'b0;
            stop_pend   <= 1'b0;
            resync_pend <= 1'b0;
        end else begin
            if (state == ST_PREFETCH && ve_rise) begin
                uf_q <= 1'b1;
            end
            if (frame_inc) begin
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end

            if (state == ST_IDLE) begin
                if (enable) begin
                    state <= ST_ARM;
                end
            end else if (state == ST_STOP) begin
                tg_q        <= 1'b0;
                req_q       <= 1'b0;
                stop_pend   <= 1'b0;
                resync_pend <= 1'b0;
                state       <= ST_IDLE;
            end else if (stopping) begin
                if (req_held) begin
                    stop_pend <= 1'b1;
                end else begin
                    req_q <= 1'b0;
                    state <= ST_STOP;
                end
            end else if (restart) begin
                // New frame, either scheduled (WAIT_VSYNC) or a mid-frame resync.
                resync_pend <= 1'b0;
                frame_base  <= fb_base;
                line_cnt    <= '0;
                burst_idx   <= '0;
                req_q       <= 1'b1;
                addr_q      <= fb_base;
                state       <= ST_PREFETCH;
            end else begin
                case (state)
                    ST_ARM: begin
                        tg_q       <= 1'b1;
                        frame_base <= fb_base;
                        line_cnt   <= '0;
                        burst_idx  <= '0;
                        req_q      <= 1'b1;
                        addr_q     <= fb_base;
                        state      <= ST_PREFETCH;
                    end
                    ST_PREFETCH: begin
                        if (vs_rise) begin
                            resync_pend <= 1'b1;
                        end else if (req_q && rd_ack) begin
                            if (burst_idx == LAST_IDX) begin
                                req_q     <= 1'b0;
                                burst_idx <= '0;
                                state     <= ST_WAIT_LINE;
                            end else begin
                                burst_idx <= burst_idx + IDX_W'(1);
                                addr_q    <= addr_q + BURST_STRIDE;
                            end
                        end
                    end
                    ST_WAIT_LINE: begin
                        if (ve_fall) begin
                            if (line_cnt == LAST_LINE) begin
                                state <= ST_WAIT_VSYNC;
                            end else begin
                                line_cnt <= line_cnt + LINE_W'(1);
                                req_q    <= 1'b1;
                                addr_q   <= line_addr(frame_base, line_cnt + LINE_W'(1));
                                state    <= ST_PREFETCH;
                            end
                        end
                    end
                    ST_WAIT_VSYNC: begin
                        state <= ST_WAIT_VSYNC;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tg_start    = tg_q;
    assign rd_req      = req_q;
    assign rd_addr     = addr_q;
    assign frame_count = frame_cnt_q;
    assign underflow   = uf_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_dvi_scanout_ctrl.sv
// Directed bench for dvi_scanout_ctrl with a 32x4 frame and 8-pixel bursts.
module tb_dvi_scanout_ctrl;

    localparam int H_ACTIVE = 32;
    localparam int V_ACTIVE = 4;
    localparam int BURST    = 8;
    localparam int ADDR_W   = 24;
    localparam int NV       = 31;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [ADDR_W-1:0] fb_base;
    logic              tg_start;
    logic              vsync_in;
    logic              ve_in;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [15:0]       frame_count;
    logic              underflow;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dvi_scanout_ctrl #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BURST    (BURST),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .fb_base     (fb_base),
        .tg_start    (tg_start),
        .vsync_in    (vsync_in),
        .ve_in       (ve_in),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .frame_count (frame_count),
        .underflow   (underflow),
        .busy        (busy)
    );

    typedef struct packed {
        logic        en;
        logic        vs;
        logic        ve;
        logic        ack;
        logic        tg;
        logic        req;
        logic [23:0] addr;
        logic        chk_addr;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic en, input logic vs, input logic ve, input logic ack,
                                input logic tg, input logic req, input logic [23:0] addr,
                                input logic chk_addr, input logic [15:0] fc);
        vec_t v;
        v.en = en; v.vs = vs; v.ve = ve; v.ack = ack;
        v.tg = tg; v.req = req; v.addr = addr; v.chk_addr = chk_addr; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic en, input logic vs, input logic ve, input logic ack);
        enable   = en;
        vsync_in = vs;
        ve_in    = ve;
        rd_ack   = ack;
        tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        vsync_in = 1'b0;
        ve_in    = 1'b0;
        rd_ack   = 1'b0;
        fb_base  = 24'h001000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic force_frame_count_ffff();
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenarios 1 and 2: enable with ack tied high, then a full 4-line frame and vsync.
        vecs[0]  = mk(1,0,0,1, 0,0,24'h000000,1, 16'd0);
        vecs[1]  = mk(1,0,0,1, 1,1,24'h001000,1, 16'd0);
        vecs[2]  = mk(1,0,0,1, 1,1,24'h001008,1, 16'd0);
        vecs[3]  = mk(1,0,0,1, 1,1,24'h001010,1, 16'd0);
        vecs[4]  = mk(1,0,0,1, 1,1,24'h001018,1, 16'd0);
        vecs[5]  = mk(1,0,0,1, 1,0,24'h000000,0, 16'd0);
        vecs[6]  = mk(1,0,1,1, 1,0,24'h000000,0, 16'd0);
        vecs[7]  = mk(1,0,0,1, 1,1,24'h001020,1, 16'd0);
        vecs[8]  = mk(1,0,0,1, 1,1,24'h001028,1, 16'd0);
        vecs[9]  = mk(1,0,0,1, 1,1,24'h001030,1, 16'd0);
        vecs[10] = mk(1,0,0,1, 1,1,24'h001038,1, 16'd0);
        vecs[11] = mk(1,0,0,1, 1,0,24'h000000,0, 16'd0);
        vecs[12] = mk(1,0,1,1, 1,0,24'h000000,0, 16'd0);
        vecs[13] = mk(1,0,0,1, 1,1,24'h001040,1, 16'd0);
        vecs[14] = mk(1,0,0,1, 1,1,24'h001048,1, 16'd0);
        vecs[15] = mk(1,0,0,1, 1,1,24'h001050,1, 16'd0);
        vecs[16] = mk(1,0,0,1, 1,1,24'h001058,1, 16'd0);
        vecs[17] = mk(1,0,0,1, 1,0,24'h000000,0, 16'd0);
        vecs[18] = mk(1,0,1,1, 1,0,24'h000000,0, 16'd0);
        vecs[19] = mk(1,0,0,1, 1,1,24'h001060,1, 16'd0);
        vecs[20] = mk(1,0,0,1, 1,1,24'h001068,1, 16'd0);
        vecs[21] = mk(1,0,0,1, 1,1,24'h001070,1, 16'd0);
        vecs[22] = mk(1,0,0,1, 1,1,24'h001078,1, 16'd0);
        vecs[23] = mk(1,0,0,1, 1,0,24'h000000,0, 16'd0);
        vecs[24] = mk(1,0,1,1, 1,0,24'h000000,0, 16'd0);
        vecs[25] = mk(1,0,0,1, 1,0,24'h000000,0, 16'd0);
        vecs[26] = mk(1,1,0,1, 1,1,24'h001000,1, 16'd1);
        vecs[27] = mk(1,0,0,1, 1,1,24'h001008,1, 16'd1);
        vecs[28] = mk(1,0,0,1, 1,1,24'h001010,1, 16'd1);
        vecs[29] = mk(1,0,0,1, 1,1,24'h001018,1, 16'd1);
        vecs[30] = mk(1,0,0,1, 1,0,24'h000000,0, 16'd1);

        do_reset();
        check("reset tg_start", tg_start, 0);
        check("reset rd_req", rd_req, 0);
        check("reset rd_addr", rd_addr, 0);
        check("reset frame_count", frame_count, 0);
        check("reset underflow", underflow, 0);
        check("reset busy", busy, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].en, vecs[i].vs, vecs[i].ve, vecs[i].ack);
            check($sformatf("vec%0d tg_start", i), tg_start, vecs[i].tg);
            check($sformatf("vec%0d rd_req", i), rd_req, vecs[i].req);
            if (vecs[i].chk_addr) check($sformatf("vec%0d rd_addr", i), rd_addr, vecs[i].addr);
            check($sformatf("vec%0d frame_count", i), frame_count, vecs[i].fc);
            check($sformatf("vec%0d busy", i), busy, 1);
            check($sformatf("vec%0d underflow", i), underflow, 0);
        end

        // Scenario 3: ack withheld for 5 cycles on the second burst.
        do_reset();
        drive(1,0,0,0);
        drive(1,0,0,0);
        check("s3 first addr", rd_addr, 24'h001000);
        drive(1,0,0,1);
        check("s3 second addr", rd_addr, 24'h001008);
        for (int k = 0; k < 5; k++) begin
            drive(1,0,0,0);
            check($sformatf("s3 hold%0d rd_req", k), rd_req, 1);
            check($sformatf("s3 hold%0d rd_addr", k), rd_addr, 24'h001008);
        end
        drive(1,0,0,1);
        check("s3 advance addr", rd_addr, 24'h001010);

        // Scenario 4: ve rises while line 1 has only 2 of 4 bursts acked.
        do_reset();
        drive(1,0,0,1);
        for (int k = 0; k < 5; k++) drive(1,0,0,1);
        check("s4 line0 done", rd_req, 0);
        drive(1,0,1,1);
        check("s4 on-time line no underflow", underflow, 0);
        drive(1,0,0,1);
        check("s4 line1 addr", rd_addr, 24'h001020);
        drive(1,0,0,1);
        drive(1,0,0,1);
        check("s4 two acked addr", rd_addr, 24'h001030);
        drive(1,0,1,0);
        check("s4 underflow set", underflow, 1);
        check("s4 req kept", rd_req, 1);
        check("s4 addr kept", rd_addr, 24'h001030);
        drive(1,0,1,1);
        drive(1,0,1,1);
        check("s4 line1 done", rd_req, 0);
        drive(1,0,0,1);
        check("s4 line2 addr", rd_addr, 24'h001040);
        for (int k = 0; k < 4; k++) drive(1,0,0,1);
        drive(1,0,1,1);
        drive(1,0,0,1);
        check("s4 line3 addr", rd_addr, 24'h001060);
        for (int k = 0; k < 4; k++) drive(1,0,0,1);
        drive(1,0,1,1);
        drive(1,0,0,1);
        drive(1,1,0,1);
        check("s4 next frame count", frame_count, 1);
        check("s4 next frame addr", rd_addr, 24'h001000);
        check("s4 underflow sticky", underflow, 1);
        for (int k = 0; k < 4; k++) drive(1,0,0,1);
        check("s4 underflow still sticky", underflow, 1);
        do_reset();
        check("s4 underflow cleared by reset", underflow, 0);

        // Scenario 5: enable drops with a request pending; ack arrives 3 cycles later.
        do_reset();
        drive(1,0,0,0);
        drive(1,0,0,0);
        drive(0,0,0,0);
        check("s5 req pending", rd_req, 1);
        check("s5 tg still on", tg_start, 1);
        drive(0,0,0,0);
        drive(0,0,0,0);
        check("s5 no new addr", rd_addr, 24'h001000);
        check("s5 req still pending", rd_req, 1);
        drive(0,0,0,1);
        check("s5 req drops after ack", rd_req, 0);
        check("s5 busy in stop", busy, 1);
        drive(0,0,0,0);
        check("s5 tg off", tg_start, 0);
        check("s5 idle", busy, 0);
        drive(0,0,0,0);
        check("s5 no further request", rd_req, 0);

        // Scenario 6a: reset mid-burst with frame_count at 0xFFFF.
        do_reset();
        drive(1,0,0,1);
        drive(1,0,0,1);
        drive(1,0,0,1);
        force_frame_count_ffff();
        check("s6 preload", frame_count, 16'hFFFF);
        reset = 1'b1;
        drive(1,0,0,1);
        check("s6 reset tg_start", tg_start, 0);
        check("s6 reset rd_req", rd_req, 0);
        check("s6 reset rd_addr", rd_addr, 0);
        check("s6 reset frame_count", frame_count, 0);
        check("s6 reset busy", busy, 0);
        reset = 1'b0;

        // Scenario 6b: wrap via resync, resync with pending ack, stop beating vsync.
        do_reset();
        drive(1,0,0,1);
        drive(1,0,0,1);
        force_frame_count_ffff();
        fb_base = 24'h002000;
        drive(1,1,0,1);
        check("s6 wrap", frame_count, 16'h0000);
        check("s6 resync addr", rd_addr, 24'h002000);
        drive(1,0,0,1);
        check("s6 post-resync addr", rd_addr, 24'h002008);
        fb_base = 24'h003000;
        drive(1,1,0,0);
        check("s6 resync count immediate", frame_count, 16'h0001);
        check("s6 resync waits for ack", rd_addr, 24'h002008);
        drive(1,0,0,1);
        check("s6 resync after ack addr", rd_addr, 24'h003000);
        check("s6 resync after ack req", rd_req, 1);
        drive(0,1,0,1);
        check("s6 stop beats vsync count", frame_count, 16'h0001);
        check("s6 stop req", rd_req, 0);
        drive(0,0,0,0);
        check("s6 stop idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
